// File: rtl/eular_pkg.sv
// Shared definitions for the Euler step scaler: FSM encoding, default format
// and saturation limits.
package eular_pkg;

   localparam int DEFAULT_FRAC_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_SAT  = 2'd2,
      ST_OUT  = 2'd3
   } eular_state_e;

   // Largest positive magnitude representable in a signed word of 'size' bits.
   function automatic logic [63:0] sat_pos_lim(input int size);
      return (64'd1 << (size - 1)) - 64'd1;
   endfunction

   // Largest negative magnitude representable in a signed word of 'size' bits.
   function automatic logic [63:0] sat_neg_lim(input int size);
      return 64'd1 << (size - 1);
   endfunction

endpackage

// File: rtl/eular_step_scaler_if.sv
// Sample/increment bus between the derivative source, the scaler and the
// Euler accumulator.
interface eular_step_scaler_if #(
   parameter int Size = 16
);
   // A sample transfers on a rising edge where in_valid and in_ready are both
   // high; in_ready does not depend on in_valid. The result side has no
   // back-pressure: out_valid is a one-cycle pulse and outp is zero otherwise.
   logic            in_valid;
   logic            in_ready;
   logic [Size-1:0] deriv;
   logic [Size-1:0] step_h;
   logic [Size-1:0] outp;
   logic            out_valid;
   logic            sat_flag;

   modport master (
      output in_valid, deriv, step_h,
      input  in_ready, outp, out_valid, sat_flag
   );

   modport slave (
      input  in_valid, deriv, step_h,
      output in_ready, outp, out_valid, sat_flag
   );
endinterface

// File: rtl/eular_seq_multiplier.sv
// Unsigned Size x Size radix-2 shift-add multiplier; one multiplier bit per
// clock, exactly Size steps after start.
module eular_seq_multiplier #(
   parameter int Size = 16
) (
   input  logic              clk,
   input  logic              rst_async_n,
   input  logic              clr,
   input  logic              start,
   input  logic [Size-1:0]   a,
   input  logic [Size-1:0]   b,
   output logic              done,
   output logic [2*Size-1:0] product
);

   localparam int CW = (Size > 1) ? $clog2(Size) : 1;

   logic [2*Size-1:0] mcand;
   logic [Size-1:0]   mplier;
   logic [CW-1:0]     cnt;
   logic              busy;

   // done marks the cycle whose edge performs the final add step
   assign done = busy && (cnt == CW'(Size - 1));

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
      end else if (clr) begin
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
      end else if (start) begin
         mcand   <= {{Size{1'b0}}, a};
         mplier  <= b;
         product <= '0;
         cnt     <= '0;
         busy    <= 1'b1;
      end else if (busy) begin
         if (mplier[0]) begin
            product <= product + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/eular_step_scaler.sv
// Forms the rounded, saturated Euler increment h*f and presents it for exactly
// one cycle; outp is zero at all other times so the accumulator can add blindly.
module eular_step_scaler
   import eular_pkg::*;
#(
   parameter int Size     = 16,
   parameter int FracBits = DEFAULT_FRAC_BITS
) (
   input  logic                 clk,
   input  logic                 rst_async_n,
   input  logic                 rst_sync,
   eular_step_scaler_if.slave   bus,
   output eular_state_e         state_dbg
);

   localparam int PW = 2 * Size + 1;
   localparam int MW = PW - FracBits;
   localparam logic [MW-1:0] POS_LIM = MW'(sat_pos_lim(Size));
   localparam logic [MW-1:0] NEG_LIM = MW'(sat_neg_lim(Size));
   localparam logic [PW-1:0] HALF_LSB = PW'(1) << (FracBits - 1);

   eular_state_e      state, state_nx;
   logic              accept;
   logic              mul_done;
   logic [Size-1:0]   deriv_abs;
   logic [2*Size-1:0] product;
   logic              sign_q;
   logic [PW-1:0]     rounded;
   logic [MW-1:0]     mag;
   logic [Size-1:0]   sat_res;
   logic              sat_hit;
   logic [Size-1:0]   result_q;
   logic              sat_q;
   logic [Size-1:0]   outp_q;
   logic              out_valid_q;
   logic              sat_flag_q;

   // rst_sync overrides a handshake so the sample is dropped
   assign accept    = (state == ST_IDLE) && bus.in_valid && !rst_sync;
   // -0x8000.. maps to 0x8000.. which is still the correct unsigned magnitude
   assign deriv_abs = bus.deriv[Size-1] ? (~bus.deriv + Size'(1)) : bus.deriv;

   eular_seq_multiplier #(.Size(Size)) u_mul (
      .clk         (clk),
      .rst_async_n (rst_async_n),
      .clr         (rst_sync),
      .start       (accept),
      .a           (deriv_abs),
      .b           (bus.step_h),
      .done        (mul_done),
      .product     (product)
   );

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         state <= ST_IDLE;
      end else if (rst_sync) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (accept)   state_nx = ST_MUL;
         ST_MUL:  if (mul_done) state_nx = ST_SAT;
         ST_SAT:  state_nx = ST_OUT;
         ST_OUT:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Round half away from zero on the magnitude, then apply sign and clamp
   assign rounded = {1'b0, product} + HALF_LSB;
   assign mag     = MW'(rounded >> FracBits);

   always_comb begin
      sat_res = '0;
      sat_hit = 1'b0;
      if (product != '0) begin
         if (!sign_q) begin
            if (mag > POS_LIM) begin
               sat_res = {1'b0, {(Size-1){1'b1}}};
               sat_hit = 1'b1;
            end else begin
               sat_res = mag[Size-1:0];
            end
         end else begin
            if (mag > NEG_LIM) begin
               sat_res = {1'b1, {(Size-1){1'b0}}};
               sat_hit = 1'b1;
            end else begin
               sat_res = ~mag[Size-1:0] + Size'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         sign_q      <= 1'b0;
         result_q    <= '0;
         sat_q       <= 1'b0;
         outp_q      <= '0;
         out_valid_q <= 1'b0;
         sat_flag_q  <= 1'b0;
      end else if (rst_sync) begin
         sign_q      <= 1'b0;
         result_q    <= '0;
         sat_q       <= 1'b0;
         outp_q      <= '0;
         out_valid_q <= 1'b0;
         sat_flag_q  <= 1'b0;
      end else begin
         if (accept) begin
            sign_q <= bus.deriv[Size-1];
         end
         if (state == ST_SAT) begin
            result_q <= sat_res;
            sat_q    <= sat_hit;
         end
         if (state == ST_OUT) begin
            outp_q      <= result_q;
            out_valid_q <= 1'b1;
            sat_flag_q  <= sat_q;
         end else begin
            outp_q      <= '0;
            out_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.outp      = outp_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sat_flag  = sat_flag_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_eular_step_scaler.sv
// Bench for eular_step_scaler: vector table, random samples, back-to-back
// handshake, reset corner cases and a downstream accumulator.
module tb_eular_step_scaler;
  import eular_pkg::*;

  localparam int W      = 16;
  localparam int FB     = 8;
  localparam int LAT    = W + 2;
  localparam int PERIOD = W + 3;

  typedef struct {
    logic [W-1:0] deriv;
    logic [W-1:0] step_h;
    logic [W-1:0] exp_out;
    logic         exp_sat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_async_n = 1'b0;
  logic         rst_sync = 1'b0;
  eular_state_e state_dbg;

  eular_step_scaler_if #(.Size(W)) bus ();

  eular_step_scaler #(.Size(W), .FracBits(FB)) dut (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .rst_sync    (rst_sync),
    .bus         (bus),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W:0] exp_q[$];
  int         acc_cyc_q[$];
  logic [W:0] exp_cur;
  bit         hs_mode   = 1'b0;
  int         last_acc  = -1;
  int         acc_count = 0;

  logic [W-1:0] acc;
  logic         acc_clr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // downstream Euler accumulator: adds outp on every clock
  always @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) acc <= '0;
    else if (acc_clr) acc <= '0;
    else              acc <= acc + bus.outp;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference: exact signed product, round half away from zero, clamp
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [W-1:0] h);
    longint p, m;
    logic [W-1:0] r;
    logic s;
    p = longint'($signed(d)) * longint'(h);
    m = (p < 0) ? -p : p;
    m = (m + (longint'(1) << (FB - 1))) >> FB;
    s = 1'b0;
    if (p >= 0) begin
      if (m > 32767) begin r = 16'h7FFF; s = 1'b1; end
      else r = W'(m);
    end else begin
      if (m > 32768) begin r = 16'h8000; s = 1'b1; end
      else r = W'(-m);
    end
    return {s, r};
  endfunction

  // scoreboard: push on accepted handshake, pop on out_valid
  always @(negedge clk) begin : mon
    logic [W:0] e;
    int a;
    if (rst_async_n) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got pulse with outp 0x%0h, required none (cycle %0d)", bus.outp, cyc);
        end else begin
          e = exp_q.pop_front();
          a = acc_cyc_q.pop_front();
          check("outp", 32'(bus.outp), 32'(e[W-1:0]));
          check("sat_flag", 32'(bus.sat_flag), 32'(e[W]));
          check("latency", 32'(cyc - a), 32'(LAT));
        end
      end else begin
        check("idle_outputs_zero", {15'd0, bus.sat_flag, bus.outp}, 32'd0);
      end
      if (bus.in_valid && bus.in_ready && !rst_sync) begin
        exp_q.push_back(exp_cur);
        acc_cyc_q.push_back(cyc + 1);
        if (hs_mode) begin
          if (last_acc >= 0) check("accept_spacing", 32'(cyc + 1 - last_acc), 32'(PERIOD));
          last_acc = cyc + 1;
          acc_count++;
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] h, input logic [W:0] e);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && n < 4 * PERIOD) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, required high", n);
    end
    bus.deriv    = d;
    bus.step_h   = h;
    exp_cur      = e;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * PERIOD) begin
      @(posedge clk);
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
      exp_q.delete();
      acc_cyc_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_outp"}, 32'(bus.outp), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_sat_flag"}, 32'(bus.sat_flag), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  vec_t vecs[10];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] d, h;
    vecs[0] = '{16'h0300, 16'h0080, 16'h0180, 1'b0};
    vecs[1] = '{16'hFD00, 16'h0080, 16'hFE80, 1'b0};
    vecs[2] = '{16'h0080, 16'h0001, 16'h0001, 1'b0};
    vecs[3] = '{16'hFF80, 16'h0001, 16'hFFFF, 1'b0};
    vecs[4] = '{16'h1000, 16'h1000, 16'h7FFF, 1'b1};
    vecs[5] = '{16'hF000, 16'h1000, 16'h8000, 1'b1};
    vecs[6] = '{16'h8000, 16'h0100, 16'h8000, 1'b0};
    vecs[7] = '{16'h0000, 16'h1234, 16'h0000, 1'b0};
    vecs[8] = '{16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1};
    vecs[9] = '{16'hFF00, 16'h0100, 16'hFF00, 1'b0};

    bus.in_valid = 1'b0;
    bus.deriv    = '0;
    bus.step_h   = '0;
    exp_cur      = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs("reset");
    rst_async_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // vector table
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].deriv, vecs[i].step_h, {vecs[i].exp_sat, vecs[i].exp_out});
      drain();
    end

    // random samples
    for (int i = 0; i < 8; i++) begin
      d = W'($urandom_range(0, 16'hFFFF));
      h = W'($urandom_range(0, 16'h0400));
      send(d, h, model(d, h));
      drain();
    end

    // in_valid held high with new data every cycle
    hs_mode   = 1'b1;
    last_acc  = -1;
    acc_count = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.deriv  = W'($urandom_range(0, 16'hFFFF));
      bus.step_h = W'($urandom_range(0, 16'h0200));
      exp_cur    = model(bus.deriv, bus.step_h);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    hs_mode = 1'b0;
    drain();
    check("accepts_in_window", 32'(acc_count), 32'd4);

    // asynchronous reset five cycles into the multiply
    send(16'h0300, 16'h0080, model(16'h0300, 16'h0080));
    repeat (5) @(posedge clk);
    #1;
    rst_async_n = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    #1;
    check_quiet_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_async_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("async_rst_release_in_ready", 32'(bus.in_ready), 32'd1);

    // synchronous clear asserted in the OUT cycle
    send(16'h1000, 16'h1000, model(16'h1000, 16'h1000));
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("sync_rst_in_out_state", 32'(state_dbg), 32'(ST_OUT));
    rst_sync = 1'b1;
    @(posedge clk); #1;
    rst_sync = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    check_quiet_outputs("sync_rst");
    repeat (25) @(posedge clk);
    #1;

    // rst_sync coincident with a handshake drops the sample
    bus.deriv    = 16'h0300;
    bus.step_h   = 16'h0080;
    exp_cur      = model(16'h0300, 16'h0080);
    bus.in_valid = 1'b1;
    rst_sync     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_sync     = 1'b0;
    check_quiet_outputs("sync_rst_hs");
    repeat (25) @(posedge clk);
    #1;

    // accumulator integration
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(16'h0100, 16'h0040, 17'h00040);
      drain();
      check("acc_after_pulse", 32'(acc), 32'(k * 16'h0040));
      repeat (5) @(posedge clk);
      #1;
      check("acc_hold", 32'(acc), 32'(k * 16'h0040));
    end
    check("acc_final", 32'(acc), 32'h0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
